imem_fetch_ctrl: RTL

//  Instruction-fetch controller that sequences the single-port instruction memory.

---
 rtl/imem_fetch_ctrl_if.sv | 38 +++
 rtl/imem_fetch_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Instruction-fetch controller bus: boot-load port, memory port and
// the fetch/decode handoff.
interface imem_fetch_ctrl_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        running;
  logic        fault;

  modport slave (
    input  load_valid, load_addr, load_data, load_done,
    input  stall, redirect_valid, redirect_pc, halt_req,
    input  mem_rdata,
    output load_ready, mem_addr, mem_we, mem_wdata,
    output if_valid, if_pc, if_instr, running, fault
  );

  modport master (
    output load_valid, load_addr, load_data, load_done,
    output stall, redirect_valid, redirect_pc, halt_req,
    output mem_rdata,
    input  load_ready, mem_addr, mem_we, mem_wdata,
    input  if_valid, if_pc, if_instr, running, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: boot-loads the single-port imem, then
// runs the PC (fetch, stall, redirect, halt) into a registered IF bundle.
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 128,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.slave  bus
);

  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        fault_q, fault_d;

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= LIMIT);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc         <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d        = state;
    pc_d           = pc;
    if_pc_d        = if_pc_q;
    if_instr_d     = if_instr_q;
    if_valid_d     = if_valid_q;
    fault_d        = fault_q;
    bus.load_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = pc;
    bus.mem_wdata  = bus.load_data;
    unique case (state)
      LOAD: begin
        bus.load_ready = !rst;
        bus.mem_addr   = bus.load_addr;
        if_valid_d     = 1'b0;
        if (bus.load_valid) begin
          if (bad_addr(bus.load_addr)) fault_d = 1'b1;
          else bus.mem_we = !rst;
        end
        if (bus.load_done) begin
          state_d = RUN;
          pc_d    = RESET_PC;
        end
      end
      RUN: begin
        // A fault latched during boot-load stops execution at once.
        if (fault_q) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else if (bus.redirect_valid) begin
          if_valid_d = 1'b0;
          if (bad_addr(bus.redirect_pc)) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d = bus.redirect_pc;
          end
        end else if (bus.halt_req) begin
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else if (bus.stall) begin
          pc_d = pc;
        end else if (bad_addr(pc)) begin
          fault_d    = 1'b1;
          state_d    = HALT;
          if_valid_d = 1'b0;
        end else begin
          if_instr_d = bus.mem_rdata;
          if_pc_d    = pc;
          if_valid_d = 1'b1;
          pc_d       = pc + 32'd4;
        end
      end
      HALT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d    = HALT;
        if_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_pc    = if_pc_q;
  assign bus.if_instr = if_instr_q;
  assign bus.fault    = fault_q;
  assign bus.running  = (state == RUN);

endmodule
